mmb_arbiter_2x1: RTL

- Two-master to one-slave arbiter for the burst MemoryMapped (mmb) interface.
- Shares a single mmb slave, such as a memory controller or register bank, between two mmb masters.
- Applies round-robin priority and holds the grant for the whole of a write burst.
- Tracks outstanding read bursts in an in-order ID queue so that returned read data is routed to the master that issued the request.

---
 rtl/mmb_arbiter_2x1.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/mmb_arbiter_2x1.sv
// Two-master to one-slave arbiter for the burst mmb interface: round-robin
// command selection, write-burst locking and in-order read-return routing.
module mmb_arbiter_2x1 #(
  parameter int DWIDTH  = 8,
  parameter int AWIDTH  = 32,
  parameter int BWIDTH  = 8,
  parameter int RDPENDS = 4
) (
  input  logic              reset,
  input  logic              clk,
  input  logic [AWIDTH-1:0] s0_addr,
  input  logic [BWIDTH-1:0] s0_bcnt,
  input  logic              s0_wreq,
  input  logic [DWIDTH-1:0] s0_wdat,
  input  logic              s0_rreq,
  output logic [DWIDTH-1:0] s0_rdat,
  output logic              s0_rval,
  output logic              s0_busy,
  input  logic [AWIDTH-1:0] s1_addr,
  input  logic [BWIDTH-1:0] s1_bcnt,
  input  logic              s1_wreq,
  input  logic [DWIDTH-1:0] s1_wdat,
  input  logic              s1_rreq,
  output logic [DWIDTH-1:0] s1_rdat,
  output logic              s1_rval,
  output logic              s1_busy,
  output logic [AWIDTH-1:0] m_addr,
  output logic [BWIDTH-1:0] m_bcnt,
  output logic              m_wreq,
  output logic [DWIDTH-1:0] m_wdat,
  output logic              m_rreq,
  input  logic [DWIDTH-1:0] m_rdat,
  input  logic              m_rval,
  input  logic              m_busy,
  output logic              rsp_err
);

  localparam int PW = (RDPENDS > 1) ? $clog2(RDPENDS) : 1;
  localparam int CW = $clog2(RDPENDS + 1);
  localparam logic [PW-1:0]     PTR_LAST = PW'(RDPENDS - 1);
  localparam logic [CW-1:0]     CNT_FULL = CW'(RDPENDS);
  localparam logic [BWIDTH-1:0] BC_ONE   = BWIDTH'(1);

  typedef enum logic {IDLE = 1'b0, WBURST = 1'b1} state_e;

  state_e            state_q, state_d;
  logic              prio_q, prio_d;
  logic              owner_q, owner_d;
  logic [BWIDTH-1:0] wcnt_q, wcnt_d;
  logic [BWIDTH-1:0] rcnt_q, rcnt_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [PW-1:0]     wptr_q, wptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              rsp_err_q, rsp_err_d;

  // ID queue payload; only entries covered by cnt_q are meaningful
  logic              id_mem [RDPENDS];
  logic [BWIDTH-1:0] bc_mem [RDPENDS];

  logic              req0, req1, sel;
  logic              sel_wreq, sel_rreq, sel_busy, rd_block;
  logic [AWIDTH-1:0] sel_addr;
  logic [BWIDTH-1:0] sel_bcnt;
  logic [DWIDTH-1:0] sel_wdat;
  logic              full, empty, wr_acc, rd_acc, push, pop, rsp_hit;
  logic              head_id;
  logic [BWIDTH-1:0] head_bc;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  assign req0 = s0_wreq | s0_rreq;
  assign req1 = s1_wreq | s1_rreq;

  always_comb begin
    sel = prio_q;
    if (state_q == WBURST)   sel = owner_q;
    else if (req0 && !req1)  sel = 1'b0;
    else if (req1 && !req0)  sel = 1'b1;
  end

  assign sel_addr = sel ? s1_addr : s0_addr;
  assign sel_bcnt = sel ? s1_bcnt : s0_bcnt;
  assign sel_wdat = sel ? s1_wdat : s0_wdat;
  assign sel_wreq = sel ? s1_wreq : s0_wreq;
  assign sel_rreq = sel ? s1_rreq : s0_rreq;

  assign full  = (cnt_q == CNT_FULL);
  assign empty = (cnt_q == '0);

  // Reads are held off while the ID queue has no room or a write burst owns the slave
  assign rd_block = full | (state_q == WBURST);

  assign m_addr = sel_addr;
  assign m_bcnt = sel_bcnt;
  assign m_wdat = sel_wdat;
  assign m_wreq = reset & sel_wreq;
  assign m_rreq = reset & sel_rreq & ~rd_block;

  assign sel_busy = m_busy | (sel_rreq & rd_block);
  assign s0_busy  = ~reset | sel | sel_busy;
  assign s1_busy  = ~reset | ~sel | sel_busy;

  assign wr_acc = m_wreq & ~m_busy;
  assign rd_acc = m_rreq & ~m_busy;
  assign push   = rd_acc;

  assign head_id = id_mem[rptr_q];
  assign head_bc = bc_mem[rptr_q];
  assign rsp_hit = m_rval & ~empty;

  assign s0_rdat = m_rdat;
  assign s1_rdat = m_rdat;
  assign s0_rval = reset & rsp_hit & ~head_id;
  assign s1_rval = reset & rsp_hit & head_id;
  assign rsp_err = rsp_err_q;

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    owner_d   = owner_q;
    wcnt_d    = wcnt_q;
    rcnt_d    = rcnt_q;
    rsp_err_d = rsp_err_q;
    pop       = 1'b0;

    case (state_q)
      IDLE: begin
        if (wr_acc) begin
          if (sel_bcnt == BC_ONE) begin
            prio_d = ~sel;
          end else begin
            // bcnt of 0 wraps to the full 2^BWIDTH-word burst
            state_d = WBURST;
            owner_d = sel;
            wcnt_d  = sel_bcnt - BC_ONE;
          end
        end
      end
      WBURST: begin
        if (wr_acc) begin
          wcnt_d = wcnt_q - BC_ONE;
          if (wcnt_q == BC_ONE) begin
            state_d = IDLE;
            prio_d  = ~owner_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (rd_acc) prio_d = ~sel;

    if (rsp_hit) begin
      if (rcnt_q == '0) begin
        rcnt_d = head_bc - BC_ONE;
        pop    = (head_bc == BC_ONE);
      end else begin
        rcnt_d = rcnt_q - BC_ONE;
        pop    = (rcnt_q == BC_ONE);
      end
    end

    if (m_rval && empty) rsp_err_d = 1'b1;

    wptr_d = push ? ptr_inc(wptr_q) : wptr_q;
    rptr_d = pop  ? ptr_inc(rptr_q) : rptr_q;
    cnt_d  = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (pop && !push) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      prio_q    <= 1'b0;
      owner_q   <= 1'b0;
      wcnt_q    <= '0;
      rcnt_q    <= '0;
      rptr_q    <= '0;
      wptr_q    <= '0;
      cnt_q     <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      owner_q   <= owner_d;
      wcnt_q    <= wcnt_d;
      rcnt_q    <= rcnt_d;
      rptr_q    <= rptr_d;
      wptr_q    <= wptr_d;
      cnt_q     <= cnt_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      id_mem[wptr_q] <= sel;
      bc_mem[wptr_q] <= sel_bcnt;
    end
  end

endmodule
